scanline_fill_engine: RTL and testbench

Parametrised successor to the fixed-size fill block. It takes a bounding box, colour pair, fill mode and layer. It accepts one coverage-mask row per scanline through a valid/ready handshake and emits one frame-buffer pixel write per covered pixel through a write/ready handshake. It sits between the shape rasteriser (mask producer) and the SRAM frame-buffer controller. It adds the following, which the previous block lacked:
- bbox validation
- checker-texture and inverted-mask modes
- layer addressing
- write back-pressure

---
 rtl/scanline_fill_engine.sv | 172 +++++++++++++++++
 tb/tb_scanline_fill_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_fill_engine.sv
// Scanline fill engine: validates a bounding box, then turns one coverage-mask row
// per scanline into per-pixel frame-buffer writes with solid/checker/inverted modes.
module scanline_fill_engine #(
    parameter int COORD_W    = 12,
    parameter int LINE_W     = 64,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int LAYER_W    = 1,
    parameter int PIX_W      = 24,
    parameter int ADDR_W     = 24,
    parameter int CHECK_LOG2 = 2
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_max,
    input  logic [PIX_W-1:0]   color,
    input  logic [PIX_W-1:0]   alt_color,
    input  logic [1:0]         fill_mode,
    input  logic [LAYER_W-1:0] layer,
    input  logic               row_valid,
    input  logic [LINE_W-1:0]  row_mask,
    output logic               row_ready,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIX_W-1:0]   mem_wdata,
    input  logic               mem_ready,
    output logic               row_done,
    output logic               all_done,
    output logic               err,
    output logic               busy
);
    localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(FB_WIDTH);
    localparam logic [ADDR_W-1:0] LAYER_STRIDE = ADDR_W'(FB_WIDTH * FB_HEIGHT);

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_ROW, SCAN, ROW_END, DONE} state_t;
    state_t state;

    logic [COORD_W-1:0] bx0, by0, bx1, by1, cur_y;
    logic [PIX_W-1:0]   col, alt;
    logic [1:0]         mode;
    logic [LAYER_W-1:0] lay;
    logic [LINE_W-1:0]  mask;
    logic [IDX_W-1:0]   idx, last_idx;

    logic [COORD_W-1:0] span;
    logic               bad;
    logic               last;
    logic [IDX_W-1:0]   p_idx;
    logic [LINE_W-1:0]  p_mask;
    logic [COORD_W-1:0] p_x;
    logic               p_eff;
    logic [ADDR_W-1:0]  p_addr;
    logic [PIX_W-1:0]   p_data;

    // Next pixel to present: pixel 0 of the incoming row, or idx+1 while scanning.
    always_comb begin
        span   = bx1 - bx0;
        bad    = (bx1 < bx0) || (by1 < by0) || (32'(span) >= LINE_W) ||
                 (32'(bx1) >= FB_WIDTH) || (32'(by1) >= FB_HEIGHT);
        last   = (idx == last_idx);
        p_idx  = (state == SCAN) ? idx + IDX_W'(1) : '0;
        p_mask = (state == SCAN) ? mask : row_mask;
        p_x    = bx0 + COORD_W'(p_idx);
        p_eff  = p_mask[p_idx] ^ (mode == 2'b10);
        p_addr = ADDR_W'(lay) * LAYER_STRIDE + ADDR_W'(cur_y) * ROW_STRIDE + ADDR_W'(p_x);
        p_data = ((mode == 2'b01) && (p_x[CHECK_LOG2] ^ cur_y[CHECK_LOG2])) ? alt : col;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            bx0       <= '0;
            by0       <= '0;
            bx1       <= '0;
            by1       <= '0;
            cur_y     <= '0;
            col       <= '0;
            alt       <= '0;
            mode      <= '0;
            lay       <= '0;
            mask      <= '0;
            idx       <= '0;
            last_idx  <= '0;
            row_ready <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            row_done  <= 1'b0;
            all_done  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            row_done <= 1'b0;
            all_done <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bx0   <= x_min;
                        by0   <= y_min;
                        bx1   <= x_max;
                        by1   <= y_max;
                        col   <= color;
                        alt   <= alt_color;
                        mode  <= fill_mode;
                        lay   <= layer;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    cur_y    <= by0;
                    last_idx <= IDX_W'(span);
                    if (bad) begin
                        err      <= 1'b1;
                        all_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        row_ready <= 1'b1;
                        state     <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (row_valid && row_ready) begin
                        row_ready <= 1'b0;
                        mask      <= row_mask;
                        idx       <= '0;
                        mem_wr    <= p_eff;
                        mem_addr  <= p_addr;
                        mem_wdata <= p_data;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // A pending write holds idx and all write outputs until accepted.
                    if (!mem_wr || mem_ready) begin
                        if (last) begin
                            mem_wr   <= 1'b0;
                            row_done <= 1'b1;
                            state    <= ROW_END;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            mem_wr    <= p_eff;
                            mem_addr  <= p_addr;
                            mem_wdata <= p_data;
                        end
                    end
                end
                ROW_END: begin
                    if (cur_y == by1) begin
                        all_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cur_y     <= cur_y + COORD_W'(1);
                        row_ready <= 1'b1;
                        state     <= WAIT_ROW;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scanline_fill_engine.sv
// Self-checking bench for scanline_fill_engine: directed scenarios plus randomized jobs
// compared against a per-pixel reference model built from bbox/mask/mode rules.
module tb_scanline_fill_engine;
    localparam int COORD_W = 12;
    localparam int LINE_W  = 64;
    localparam int FB_W    = 640;
    localparam int FB_H    = 480;
    localparam int LAYER_W = 1;
    localparam int PIX_W   = 24;
    localparam int ADDR_W  = 24;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               start;
    logic [COORD_W-1:0] x_min, y_min, x_max, y_max;
    logic [PIX_W-1:0]   color, alt_color;
    logic [1:0]         fill_mode;
    logic [LAYER_W-1:0] layer;
    logic               row_valid;
    logic [LINE_W-1:0]  row_mask;
    logic               row_ready;
    logic               mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIX_W-1:0]   mem_wdata;
    logic               mem_ready;
    logic               row_done, all_done, err, busy;

    always #5 clk = ~clk;

    scanline_fill_engine #(
        .COORD_W(COORD_W), .LINE_W(LINE_W), .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H),
        .LAYER_W(LAYER_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .CHECK_LOG2(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .x_min(x_min), .y_min(y_min), .x_max(x_max), .y_max(y_max),
        .color(color), .alt_color(alt_color), .fill_mode(fill_mode), .layer(layer),
        .row_valid(row_valid), .row_mask(row_mask), .row_ready(row_ready),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .row_done(row_done), .all_done(all_done), .err(err), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: address and colour of a pixel from the frame-buffer rules.
    function automatic logic [ADDR_W-1:0] addr_of(input int lay, input int x, input int y);
        longint v;
        v = longint'(lay) * FB_W * FB_H + longint'(y) * FB_W + longint'(x);
        return ADDR_W'(v);
    endfunction

    function automatic logic [PIX_W-1:0] data_of(input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] a,
                                                 input logic [1:0] m, input int x, input int y);
        if (m == 2'b01 && ((x / 4 + y / 4) % 2 == 1)) return a;
        return c;
    endfunction

    logic [47:0]       exp_q[$];
    logic [63:0]       job_mask[$];
    logic [47:0]       mon_e;
    int                acc_cnt, rd_cnt, ad_cnt, err_cnt, rr_seen, stall_seen, stall_used;
    int                rmode = 0;
    logic              stalled = 1'b0;
    logic [ADDR_W-1:0] held_addr;
    logic [PIX_W-1:0]  held_data;

    always @(negedge clk) begin
        if (!n_rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_wr_held", mem_wr, 1);
                check("stall_addr_held", mem_addr, held_addr);
                check("stall_data_held", mem_wdata, held_data);
            end
            if (mem_wr && mem_ready) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, mon_e[47:24]);
                    check("wr_data", mem_wdata, mon_e[23:0]);
                end
                acc_cnt++;
            end
            stalled   = mem_wr && !mem_ready;
            held_addr = mem_addr;
            held_data = mem_wdata;
            if (stalled)   stall_seen++;
            if (row_done)  rd_cnt++;
            if (all_done)  ad_cnt++;
            if (err)       err_cnt++;
            if (row_ready) rr_seen++;
        end
    end

    // mem_ready: 0 always ready, 1 random, 2 three-cycle stall on 2nd pixel, 3 stall after 1st write
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            2: begin
                mem_ready = !(acc_cnt == 1 && stall_used < 3);
                if (!mem_ready) stall_used++;
            end
            default: mem_ready = (acc_cnt == 0);
        endcase
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_row_ready"}, row_ready, 0);
        check({tag, "_row_done"}, row_done, 0);
        check({tag, "_all_done"}, all_done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic set_mask(input int n, input logic [63:0] low, input int w);
        logic [63:0] wm;
        logic [63:0] r;
        wm = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        job_mask.delete();
        for (int i = 0; i < n; i++) begin
            r = {$urandom, $urandom};
            job_mask.push_back((r & ~wm) | (low & wm));
        end
    endtask

    task automatic start_job(input int x0, input int y0, input int x1, input int y1,
                             input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] a,
                             input logic [1:0] m, input int lay, input int rm, input bit bad);
        rmode = rm;
        acc_cnt = 0; rd_cnt = 0; ad_cnt = 0; err_cnt = 0; rr_seen = 0;
        stall_seen = 0; stall_used = 0;
        x_min = COORD_W'(x0); y_min = COORD_W'(y0);
        x_max = COORD_W'(x1); y_max = COORD_W'(y1);
        color = c; alt_color = a; fill_mode = m; layer = LAYER_W'(lay);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_min = COORD_W'($urandom); y_min = COORD_W'($urandom);
        x_max = COORD_W'($urandom); y_max = COORD_W'($urandom);
        color = PIX_W'($urandom); alt_color = PIX_W'($urandom);
        fill_mode = 2'($urandom); layer = LAYER_W'($urandom);
        check("busy_in_check", busy, 1);
        @(posedge clk); #1;
        check("err_latency", err, bad);
        check("all_done_latency", all_done, bad);
        check("row_ready_latency", row_ready, !bad);
    endtask

    task automatic feed_rows(input int nrows);
        int cyc;
        for (int r = 0; r < nrows; r++) begin
            cyc = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            while (!row_ready && cyc < 3000) begin @(posedge clk); #1; cyc++; end
            check("row_ready_wait", row_ready, 1);
            if (!row_ready) return;
            row_valid = 1'b1;
            row_mask  = job_mask[r];
            start     = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            row_valid = 1'b0;
            start     = 1'b0;
            row_mask  = {$urandom, $urandom};
        end
    endtask

    task automatic finish_job(input int nrows, input bit bad, input int n_exp, input string tag);
        int cyc;
        cyc = 0;
        while (ad_cnt == 0 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        check({tag, "_all_done_seen"}, ad_cnt, 1);
        check({tag, "_busy_falls"}, busy, 0);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_writes"}, acc_cnt, n_exp);
        check({tag, "_rows_done"}, rd_cnt, bad ? 0 : nrows);
        check({tag, "_err_pulses"}, err_cnt, bad);
        check({tag, "_all_done_pulses"}, ad_cnt, 1);
        if (bad) check({tag, "_no_row_ready"}, rr_seen, 0);
    endtask

    task automatic run_job(input int x0, input int y0, input int x1, input int y1,
                           input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] a,
                           input logic [1:0] m, input int lay, input int rm, input string tag);
        bit          bad;
        int          nrows;
        int          n_exp;
        logic [63:0] mk;
        bad = (x1 < x0) || (y1 < y0) || (x1 - x0 >= LINE_W) || (x1 >= FB_W) || (y1 >= FB_H);
        nrows = bad ? 0 : y1 - y0 + 1;
        exp_q.delete();
        for (int y = y0; y < y0 + nrows; y++) begin
            mk = job_mask[y - y0];
            for (int i = 0; i <= x1 - x0; i++)
                if (mk[i] ^ (m == 2'b10))
                    exp_q.push_back({addr_of(lay, x0 + i, y), data_of(c, a, m, x0 + i, y)});
        end
        n_exp = exp_q.size();
        start_job(x0, y0, x1, y1, c, a, m, lay, rm, bad);
        feed_rows(nrows);
        finish_job(nrows, bad, n_exp, tag);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int x0, y0, w, h;
        n_rst = 1'b0; start = 1'b0; row_valid = 1'b0; row_mask = '0; mem_ready = 1'b1;
        x_min = '0; y_min = '0; x_max = '0; y_max = '0;
        color = '0; alt_color = '0; fill_mode = '0; layer = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;

        set_mask(2, 64'hF, 4);
        run_job(10, 20, 13, 21, 24'hFF0000, 24'h000000, 2'b00, 0, 0, "solid");
        set_mask(1, 64'h9, 4);
        run_job(10, 20, 13, 20, 24'h00AA55, 24'h000000, 2'b00, 1, 0, "sparse");
        set_mask(1, 64'hFF, 8);
        run_job(0, 0, 7, 0, 24'h0000FF, 24'h00FF00, 2'b01, 0, 0, "checker_y0");
        set_mask(1, 64'hFF, 8);
        run_job(0, 4, 7, 4, 24'h0000FF, 24'h00FF00, 2'b01, 0, 0, "checker_y4");
        set_mask(1, 64'hF, 4);
        run_job(100, 7, 103, 7, 24'h123456, 24'h000000, 2'b11, 0, 2, "backpressure");
        check("backpressure_stall_cycles", stall_seen, 3);
        run_job(0, 0, 64, 0, 24'h111111, 24'h222222, 2'b00, 0, 0, "bad_width");
        run_job(0, 5, 3, 4, 24'h111111, 24'h222222, 2'b00, 0, 0, "bad_y_order");
        set_mask(1, 64'h0, 0);
        run_job(576, 479, 639, 479, 24'hABCDEF, 24'h000000, 2'b10, 1, 1, "corner_max");

        // inverted row, reset while the idx-3 write is held by mem_ready=0
        set_mask(1, 64'h6, 4);
        exp_q.delete();
        exp_q.push_back({addr_of(0, 10, 20), 24'h123456});
        start_job(10, 20, 13, 20, 24'h123456, 24'h000000, 2'b10, 0, 3, 1'b0);
        feed_rows(1);
        cyc = 0;
        while (!(mem_wr && acc_cnt == 1) && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("inv_held_wr", mem_wr, 1);
        check("inv_held_addr", mem_addr, addr_of(0, 13, 20));
        n_rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        n_rst = 1'b1;
        rmode = 0;
        repeat (4) begin @(posedge clk); #1; end
        check("mid_reset_no_row_done", rd_cnt, 0);
        check("mid_reset_no_all_done", ad_cnt, 0);
        check("mid_reset_writes", acc_cnt, 1);
        set_mask(1, 64'h6, 4);
        run_job(10, 20, 13, 20, 24'h123456, 24'h000000, 2'b10, 0, 0, "after_reset");

        for (int k = 0; k < 25; k++) begin
            x0 = $urandom_range(0, 639);
            y0 = $urandom_range(0, 479);
            w  = $urandom_range(1, 65);
            h  = $urandom_range(1, 3);
            set_mask(h, 64'h0, 0);
            run_job(x0, y0, x0 + w - 1, y0 + h - 1, PIX_W'($urandom), PIX_W'($urandom),
                    2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
